// File: rtl/led_strip_sequencer.sv
// Frame sequencer: walks NUM_LEDS pixels from a sync RAM, scales them by a global brightness, reorders RGB->GRB and feeds the bit driver.
// Latency: start sampled in cycle 0 -> FETCH in cycle 1 -> drv_load in cycle 3; frame_done RESET_CYCLES+1 cycles after the last drv_done.
// Backpressure: each word waits for the driver's done pulse (bounded by DONE_TIMEOUT); start while busy collapses into one pending frame.
module led_strip_sequencer #(
    parameter int NUM_LEDS     = 8,
    parameter int ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    parameter int RESET_CYCLES = 7200,
    parameter int DONE_TIMEOUT = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        i_brightness,
    output logic [ADDR_W-1:0] o_pix_addr,
    input  logic [23:0]       i_pix_data,
    output logic [23:0]       o_drv_rgb,
    output logic              o_drv_load,
    input  logic              i_drv_done,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err
);

    // One counter serves both the per-word timeout and the latch interval.
    localparam int CNT_MAX = (RESET_CYCLES > DONE_TIMEOUT) ? RESET_CYCLES : DONE_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_LOAD    = 3'd3,
        S_SEND    = 3'd4,
        S_LATCH   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [23:0]       r_drv_rgb;
    logic [7:0]        r_bri_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_pending;

    logic              w_accept;
    logic              w_advance;
    logic              w_timeout;
    logic [7:0]        w_r;
    logic [7:0]        w_g;
    logic [7:0]        w_b;

    // (c * (bri + 1)) >> 8 at 16 bits: bri=255 is identity, bri=0 blanks.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] bri);
        logic [15:0] prod;
        prod = 16'(c) * (16'(bri) + 16'd1);
        return prod[15:8];
    endfunction

    assign w_r = scale(i_pix_data[23:16], r_bri_q);
    assign w_g = scale(i_pix_data[15:8],  r_bri_q);
    assign w_b = scale(i_pix_data[7:0],   r_bri_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the frame-accept / advance / timeout strobes.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_advance = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_FETCH:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_LOAD;
            S_LOAD:    w_next = S_SEND;
            S_SEND: begin
                if (i_drv_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_next = S_LATCH;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = S_FETCH;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_cnt == LATCH_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start arriving in DONE itself is folded into the pending request.
                if (r_pending || i_start) begin
                    w_accept = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pixel index and RAM address; the address is set on entry to FETCH so the RAM data lands in CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_pix_addr <= '0;
        end else if (w_accept) begin
            r_idx      <= '0;
            r_pix_addr <= '0;
        end else if (w_advance) begin
            r_idx      <= r_idx + ADDR_W'(1);
            r_pix_addr <= r_idx + ADDR_W'(1);
        end
    end

    // Brightness latch and sticky error: both refreshed only when a frame is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bri_q <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_bri_q <= i_brightness;
            r_err   <= 1'b0;
        end else if (w_timeout) begin
            r_err   <= 1'b1;
        end
    end

    // Output word is captured once per pixel and held through LOAD and SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drv_rgb <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_drv_rgb <= {w_g, w_r, w_b};
        end
    end

    // Cycle counter: starts at 0 in LOAD and keeps running into SEND so the timeout fires DONE_TIMEOUT cycles after the load; restarts on entry to LATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) && (r_state != S_LOAD)) begin
            r_cnt <= '0;
        end else if (r_state == S_LOAD || r_state == S_SEND || r_state == S_LATCH) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Requests seen while busy collapse into a single pending frame, consumed in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_accept && r_state == S_DONE) begin
            r_pending <= 1'b0;
        end else if (i_start && r_state != S_IDLE) begin
            r_pending <= 1'b1;
        end
    end

    assign o_pix_addr   = r_pix_addr;
    assign o_drv_rgb    = r_drv_rgb;
    assign o_drv_load   = (r_state == S_LOAD);
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = (r_state == S_DONE) && !r_err;
    assign o_err        = r_err;

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Bench for led_strip_sequencer: RAM and WS2812 driver models, randomized frames checked against a per-frame reference model.
// Latency, timeout, latch interval, pending-request and reset behaviour are measured in cycles from monitor timestamps.
// The driver model answers each load after a programmable delay (0 = never answers).
`timescale 1ns/1ps
module tb_led_strip_sequencer;

    localparam int NL = 3;
    localparam int AW = 2;
    localparam int RC = 200;
    localparam int DT = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    brightness = 8'd0;
    logic [AW-1:0] pix_addr;
    logic [23:0]   pix_data = 24'd0;
    logic [23:0]   drv_rgb;
    logic          drv_load;
    logic          drv_done = 1'b0;
    logic          busy;
    logic          frame_done;
    logic          err;

    always #21 clk = ~clk;

    led_strip_sequencer #(
        .NUM_LEDS(NL), .ADDR_W(AW), .RESET_CYCLES(RC), .DONE_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_brightness(brightness),
        .o_pix_addr(pix_addr), .i_pix_data(pix_data), .o_drv_rgb(drv_rgb),
        .o_drv_load(drv_load), .i_drv_done(drv_done), .o_busy(busy),
        .o_frame_done(frame_done), .o_err(err)
    );

    // Synchronous pixel RAM model.
    logic [23:0] ram [4];
    always @(posedge clk) pix_data <= ram[pix_addr];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor and driver model, both evaluated at the falling edge.
    int cyc = 0, drv_delay = 20, cd = 0;
    int last_done_cyc = -1, err_rise_cyc = -1, busy_drop_cyc = -1;
    int n_busy_drops = 0, n_double_load = 0;
    bit spur_req = 0, prev_busy = 0, prev_err = 0, prev_load = 0;
    logic [23:0] load_w[$];
    int load_c[$];
    int fd_c[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (drv_load === 1'b1) begin
            load_w.push_back(drv_rgb);
            load_c.push_back(cyc);
            if (prev_load) n_double_load++;
        end
        prev_load = (drv_load === 1'b1);
        if (frame_done === 1'b1) fd_c.push_back(cyc);
        if (err === 1'b1 && !prev_err) err_rise_cyc = cyc;
        prev_err = (err === 1'b1);
        if (busy === 1'b0 && prev_busy) begin
            busy_drop_cyc = cyc;
            n_busy_drops++;
        end
        prev_busy = (busy === 1'b1);
        drv_done = 1'b0;
        if (rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    drv_done = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            if (drv_load === 1'b1 && drv_delay > 0) cd = drv_delay;
        end
        if (spur_req) begin
            drv_done = 1'b1;
            spur_req = 0;
        end
    end

    // Reference: per-channel integer scaling, output order G,R,B.
    function automatic logic [23:0] exp_word(input logic [23:0] px, input int bri);
        int r, g, b;
        r = (int'(px[23:16]) * (bri + 1)) / 256;
        g = (int'(px[15:8])  * (bri + 1)) / 256;
        b = (int'(px[7:0])   * (bri + 1)) / 256;
        return {8'(g), 8'(r), 8'(b)};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(output int sc);
        start = 1'b1;
        sc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        load_w.delete();
        load_c.delete();
        fd_c.delete();
        n_double_load = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_loads(input string tag, input int k, input int budget);
        int n = 0;
        while (load_w.size() < k && n < budget) begin
            tick();
            n++;
        end
        check(tag, load_w.size(), k);
    endtask

    task automatic check_words(input string tag, input int base, input int bri);
        for (int i = 0; i < NL; i++)
            check($sformatf("%s_w%0d", tag, i), load_w[base + i], exp_word(ram[i], bri));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_load"}, drv_load, 0);
        check({tag, "_fd"}, frame_done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_addr"}, pix_addr, 0);
        check({tag, "_rgb"}, drv_rgb, 0);
    endtask

    initial begin
        int sc, bri, drops0, nl;
        logic [AW-1:0] addr0;

        for (int i = 0; i < 4; i++) ram[i] = 24'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Primary-colour frame at full brightness with 720-cycle driver.
        ram[0] = 24'hFF0000; ram[1] = 24'h00FF00; ram[2] = 24'h0000FF;
        brightness = 8'd255;
        drv_delay = 720;
        clear_log();
        pulse_start(sc);
        wait_idle("t1_idle", 5000);
        check("t1_latency", load_c[0] - sc, 3);
        check("t1_nloads", load_w.size(), NL);
        check("t1_w0", load_w[0], 24'h00FF00);
        check("t1_w1", load_w[1], 24'hFF0000);
        check("t1_w2", load_w[2], 24'h0000FF);
        check("t1_nfd", fd_c.size(), 1);
        check("t1_fd_time", fd_c[0] - last_done_cyc, RC + 1);
        check("t1_busy_fall", busy_drop_cyc - fd_c[0], 1);
        check("t1_single_loads", n_double_load, 0);

        // Half brightness on a known pixel, with brightness changed mid-frame.
        ram[0] = 24'h80FF40; ram[1] = $urandom; ram[2] = $urandom;
        brightness = 8'd127;
        drv_delay = 10;
        clear_log();
        pulse_start(sc);
        brightness = 8'd3;
        wait_idle("t2_idle", 1000);
        check("t2_w0_const", load_w[0], 24'h7F4020);
        check_words("t2", 0, 127);
        check("t2_nfd", fd_c.size(), 1);

        // Zero brightness blanks every word but still completes.
        brightness = 8'd0;
        clear_log();
        pulse_start(sc);
        wait_idle("t3_idle", 1000);
        for (int i = 0; i < NL; i++) check($sformatf("t3_zero%0d", i), load_w[i], 24'd0);
        check("t3_nfd", fd_c.size(), 1);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NL; i++) ram[i] = 24'($urandom);
            bri = $urandom_range(0, 255);
            brightness = 8'(bri);
            drv_delay = $urandom_range(3, 40);
            clear_log();
            pulse_start(sc);
            brightness = 8'($urandom);
            wait_idle($sformatf("rnd%0d_idle", f), 1000);
            check_words($sformatf("rnd%0d", f), 0, bri);
            check($sformatf("rnd%0d_nfd", f), fd_c.size(), 1);
        end

        // Three requests during SEND of pixel 1 give exactly one back-to-back frame.
        bri = 200;
        brightness = 8'(bri);
        drv_delay = 30;
        clear_log();
        drops0 = n_busy_drops;
        pulse_start(sc);
        wait_loads("pend_l2", 2, 200);
        for (int k = 0; k < 3; k++) begin
            pulse_start(sc);
            tick();
        end
        wait_idle("pend_idle", 2000);
        check("pend_nloads", load_w.size(), 2 * NL);
        check("pend_nfd", fd_c.size(), 2);
        check("pend_drops", n_busy_drops - drops0, 1);
        check("pend_refetch", load_c[NL] - fd_c[0], 3);
        check_words("pend_f2", NL, bri);

        // Driver never answers: timeout, latch, no frame_done.
        drv_delay = 0;
        brightness = 8'd255;
        clear_log();
        pulse_start(sc);
        wait_idle("to_idle", DT + RC + 100);
        check("to_nloads", load_w.size(), 1);
        check("to_err_time", err_rise_cyc - load_c[0], DT);
        check("to_nfd", fd_c.size(), 0);
        check("to_latch_len", busy_drop_cyc - err_rise_cyc, RC + 1);
        check("to_err_sticky", err, 1);
        drv_delay = 10;
        clear_log();
        pulse_start(sc);
        check("to_err_clear", err, 0);
        wait_idle("to2_idle", 1000);
        check("to2_nfd", fd_c.size(), 1);

        // Spurious done in IDLE.
        addr0 = pix_addr;
        clear_log();
        spur_req = 1;
        repeat (3) tick();
        check("spur_idle_busy", busy, 0);
        check("spur_idle_addr", pix_addr, addr0);
        check("spur_idle_loads", load_w.size(), 0);

        // Spurious done in LATCH.
        drv_delay = 15;
        clear_log();
        pulse_start(sc);
        wait_loads("spl_l3", 3, 300);
        repeat (30) tick();
        spur_req = 1;
        tick();
        spur_req = 1;
        wait_idle("spl_idle", 1000);
        check("spl_nloads", load_w.size(), NL);
        check("spl_nfd", fd_c.size(), 1);
        check("spl_fd_time", fd_c[0] - last_done_cyc, RC + 1);

        // Reset mid-SEND.
        drv_delay = 25;
        clear_log();
        pulse_start(sc);
        wait_loads("rs_l2", 2, 300);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_send");
        rst = 1'b0;
        nl = load_w.size();
        repeat (60) tick();
        check("rst_send_noload", load_w.size(), nl);

        // Reset mid-LATCH.
        clear_log();
        pulse_start(sc);
        wait_loads("rl_l3", 3, 300);
        repeat (40) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_latch");
        rst = 1'b0;
        repeat (RC + 50) tick();
        check("rst_latch_noload", load_w.size(), NL);
        check("rst_latch_nofd", fd_c.size(), 0);

        // Recovery after reset.
        clear_log();
        pulse_start(sc);
        wait_idle("rec_idle", 1000);
        check("rec_nloads", load_w.size(), NL);
        check("rec_nfd", fd_c.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
